// File: rtl/booth_divider_if.sv
// Operand/result bundle for booth_divider; shares the Booth multiplier's issue conventions.
// The master side issues operations and the slave side is the divider.
interface booth_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             en;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             enableOutput;
    logic             divByZero;

    modport master (
        output en, dividend, divisor,
        input  quotient, remainder, busy, enableOutput, divByZero
    );

    modport slave (
        input  en, dividend, divisor,
        output quotient, remainder, busy, enableOutput, divByZero
    );
endinterface

// File: rtl/booth_divider.sv
// Sequential signed divider: radix-2 non-restoring division on operand magnitudes,
// one quotient bit per clock, then a restore and sign fix-up step. C-style semantics.
module booth_divider #(
    parameter int unsigned WIDTH = 32
) (
    input logic              clk,
    input logic              reset,
    booth_divider_if.slave   bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StDivide, StFix} state_e;

    state_e           state;
    logic [WIDTH:0]   p;        // signed partial remainder, bit WIDTH is the sign
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dmag;
    logic             neg_dd;
    logic             neg_dv;
    logic             dz;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             busy_flag;
    logic             pulse;
    logic             dz_flag;

    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   p_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH:0]   p_fix;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] dd_mag;
    logic [WIDTH-1:0] dv_mag;

    always_comb begin
        p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
        p_step  = p[WIDTH] ? (p_shift + {1'b0, dmag}) : (p_shift - {1'b0, dmag});
        q_step  = {q[WIDTH-2:0], ~p_step[WIDTH]};
        p_fix   = p[WIDTH] ? (p + {1'b0, dmag}) : p;
        r_mag   = p_fix[WIDTH-1:0];
        // MIN negates to itself, which read unsigned is exactly 2^(WIDTH-1)
        dd_mag  = bus.dividend[WIDTH-1] ? (-bus.dividend) : bus.dividend;
        dv_mag  = bus.divisor[WIDTH-1] ? (-bus.divisor) : bus.divisor;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= StIdle;
            p         <= '0;
            q         <= '0;
            dmag      <= '0;
            neg_dd    <= 1'b0;
            neg_dv    <= 1'b0;
            dz        <= 1'b0;
            cnt       <= '0;
            quot      <= '0;
            rem       <= '0;
            busy_flag <= 1'b0;
            pulse     <= 1'b0;
            dz_flag   <= 1'b0;
        end else begin
            pulse <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.en) begin
                        neg_dd    <= bus.dividend[WIDTH-1];
                        neg_dv    <= bus.divisor[WIDTH-1];
                        dmag      <= dv_mag;
                        dz        <= (bus.divisor == '0);
                        p         <= '0;
                        q         <= dd_mag;
                        cnt       <= '0;
                        busy_flag <= 1'b1;
                        state     <= (bus.divisor == '0) ? StFix : StDivide;
                    end
                end
                StDivide: begin
                    p   <= p_step;
                    q   <= q_step;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= StFix;
                    end
                end
                StFix: begin
                    p <= p_fix;
                    if (dz) begin
                        // Q still holds |dividend|; re-signing it returns the dividend unchanged
                        quot <= '1;
                        rem  <= neg_dd ? (-q) : q;
                    end else begin
                        quot <= (neg_dd ^ neg_dv) ? (-q) : q;
                        rem  <= neg_dd ? (-r_mag) : r_mag;
                    end
                    dz_flag   <= dz;
                    pulse     <= 1'b1;
                    busy_flag <= 1'b0;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.quotient     = quot;
    assign bus.remainder    = rem;
    assign bus.busy         = busy_flag;
    assign bus.enableOutput = pulse;
    assign bus.divByZero    = dz_flag;
endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider: directed scenarios plus random operands
// compared against a plain-arithmetic C-division model.
module tb_booth_divider;
    localparam int W = 32;
    localparam logic [W-1:0] MIN = 32'h8000_0000;
    localparam logic [W-1:0] MAX = 32'h7FFF_FFFF;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    booth_divider_if #(.WIDTH(W)) bus ();

    booth_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eq, output logic [W-1:0] er, output logic edz);
        longint sa, sb, t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == '0) begin
            eq = '1;
            er = a;
            edz = 1'b1;
        end else begin
            t = sa / sb;
            eq = t[W-1:0];
            t = sa % sb;
            er = t[W-1:0];
            edz = 1'b0;
        end
    endtask

    // Issues one operation and waits (bounded) for its pulse; lat is capture-to-result edges.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                          output int lat, output bit done);
        @(negedge clk);
        bus.en = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        @(negedge clk);
        bus.en = 1'b0;
        lat = 0;
        done = 1'b0;
        while (lat < 100) begin
            if (bus.enableOutput) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        q = bus.quotient;
        r = bus.remainder;
        dz = bus.divByZero;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.en = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.quotient, bus.remainder, bus.busy, bus.enableOutput, bus.divByZero} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: q=%h r=%h busy=%b pulse=%b dz=%b, want all 0",
                     bus.quotient, bus.remainder, bus.busy, bus.enableOutput, bus.divByZero);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [W-1:0] q, r;
        logic dz;
        int lat;
        bit done;
        run_op(32'd100, 32'd7, q, r, dz, lat, done);
        n_tests++;
        if (!done || lat != 33) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d (done=%b), want 33", lat, done);
        end
        n_tests++;
        if (q !== 32'd14 || r !== 32'd2 || dz !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_100_7: q=%0d r=%0d dz=%b busy=%b, want 14 2 0 0",
                     $signed(q), $signed(r), dz, bus.busy);
        end
        @(negedge clk);
        n_tests++;
        if (bus.enableOutput !== 1'b0 || bus.quotient !== 32'd14) begin
            n_fail++;
            $display("FAIL basic_pulse_hold: pulse=%b q=%0d, want 0 and 14",
                     bus.enableOutput, bus.quotient);
        end
    endtask

    task automatic test_signs();
        logic [W-1:0] ta[3] = '{-32'sd100, 32'sd100, -32'sd100};
        logic [W-1:0] tb[3] = '{32'sd7, -32'sd7, -32'sd7};
        logic [W-1:0] tq[3] = '{-32'sd14, -32'sd14, 32'sd14};
        logic [W-1:0] tr[3] = '{-32'sd2, 32'sd2, -32'sd2};
        logic [W-1:0] q, r;
        logic dz;
        int lat;
        bit done;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], q, r, dz, lat, done);
            n_tests++;
            if (!done || q !== tq[i] || r !== tr[i] || dz !== 1'b0) begin
                n_fail++;
                $display("FAIL signs_%0d: q=%0d r=%0d dz=%b done=%b, want %0d %0d 0", i,
                         $signed(q), $signed(r), dz, done, $signed(tq[i]), $signed(tr[i]));
            end
        end
    endtask

    task automatic test_edges();
        logic [W-1:0] ta[4] = '{MIN, MIN, 32'd5, 32'd9};
        logic [W-1:0] tb[4] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd3};
        logic [W-1:0] tq[4] = '{MIN, MIN, 32'hFFFF_FFFF, 32'd3};
        logic [W-1:0] tr[4] = '{32'd0, 32'd0, 32'd5, 32'd0};
        logic         tz[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int           tl[4] = '{33, 33, 1, 33};
        logic [W-1:0] q, r;
        logic dz;
        int lat;
        bit done;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], q, r, dz, lat, done);
            n_tests++;
            if (!done || lat != tl[i] || q !== tq[i] || r !== tr[i] || dz !== tz[i]) begin
                n_fail++;
                $display("FAIL edges_%0d: q=%h r=%h dz=%b lat=%0d, want %h %h %b %0d", i,
                         q, r, dz, lat, tq[i], tr[i], tz[i], tl[i]);
            end
        end
    endtask

    task automatic test_control();
        int pulses, pc;
        logic [W-1:0] pq, pr, q, r;
        logic dz;
        int lat;
        bit done;
        pulses = 0;
        pc = -1;
        pq = '0;
        pr = '0;
        @(negedge clk);
        bus.en = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor = 32'd7;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            bus.en = 1'b0;
            if (c == 10) begin
                n_tests++;
                if (bus.busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ctrl_busy: busy=%b, want 1", bus.busy);
                end
                bus.en = 1'b1;
                bus.dividend = 32'd50;
                bus.divisor = 32'd5;
            end
            if (bus.enableOutput) begin
                pulses++;
                pc = c;
                pq = bus.quotient;
                pr = bus.remainder;
            end
        end
        bus.en = 1'b0;
        n_tests++;
        if (pulses != 1 || pc != 33 || pq !== 32'd14 || pr !== 32'd2) begin
            n_fail++;
            $display("FAIL ctrl_ignore_en: pulses=%0d at=%0d q=%0d r=%0d, want 1 33 14 2",
                     pulses, pc, pq, pr);
        end

        pulses = 0;
        @(negedge clk);
        bus.en = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor = 32'd7;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            bus.en = 1'b0;
            if (c == 20) reset = 1'b0;
            if (c == 21) begin
                n_tests++;
                if ({bus.quotient, bus.remainder, bus.busy, bus.enableOutput,
                     bus.divByZero} !== '0) begin
                    n_fail++;
                    $display("FAIL ctrl_reset_mid: q=%h r=%h busy=%b pulse=%b dz=%b, want 0",
                             bus.quotient, bus.remainder, bus.busy, bus.enableOutput,
                             bus.divByZero);
                end
                reset = 1'b1;
            end
            if (bus.enableOutput) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL ctrl_reset_nopulse: pulses=%0d, want 0", pulses);
        end
        run_op(32'd9, 32'd2, q, r, dz, lat, done);
        n_tests++;
        if (!done || q !== 32'd4 || r !== 32'd1 || dz !== 1'b0) begin
            n_fail++;
            $display("FAIL ctrl_after_reset: q=%0d r=%0d dz=%b, want 4 1 0", q, r, dz);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ta[4] = '{32'd1000, -32'sd77, 32'd123456, MIN};
        logic [W-1:0] tb[4] = '{-32'sd3, 32'd5, 32'd789, 32'd7};
        logic [W-1:0] eq, er;
        logic edz;
        int k, c, last;
        k = 0;
        c = 0;
        last = 0;
        @(negedge clk);
        bus.en = 1'b1;
        bus.dividend = ta[0];
        bus.divisor = tb[0];
        while (k < 4 && c < 200) begin
            @(negedge clk);
            c++;
            if (bus.enableOutput) begin
                model(ta[k], tb[k], eq, er, edz);
                n_tests++;
                if (bus.quotient !== eq || bus.remainder !== er || bus.divByZero !== edz) begin
                    n_fail++;
                    $display("FAIL b2b_value_%0d: q=%h r=%h dz=%b, want %h %h %b", k,
                             bus.quotient, bus.remainder, bus.divByZero, eq, er, edz);
                end
                if (k > 0) begin
                    n_tests++;
                    if (c - last != 34) begin
                        n_fail++;
                        $display("FAIL b2b_spacing_%0d: got %0d clocks, want 34", k, c - last);
                    end
                end
                last = c;
                k++;
                if (k < 4) begin
                    bus.dividend = ta[k];
                    bus.divisor = tb[k];
                end else begin
                    bus.en = 1'b0;
                end
            end
        end
        bus.en = 1'b0;
        n_tests++;
        if (k != 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d pulses, want 4", k);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_extra_op: busy=%b, want 0", bus.busy);
        end
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] sp[7] = '{32'd0, 32'd1, 32'hFFFF_FFFF, MIN, MAX, 32'd2, 32'hFFFF_FFFE};
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 3) return sp[$urandom_range(0, 6)];
        if (sel < 5) return W'($urandom_range(0, 300)) - W'(150);
        return W'($urandom);
    endfunction

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er;
        logic dz, edz;
        int lat;
        bit done;
        for (int i = 0; i < 1200; i++) begin
            a = pick();
            b = pick();
            model(a, b, eq, er, edz);
            run_op(a, b, q, r, dz, lat, done);
            n_tests++;
            if (!done || lat != ((b == '0) ? 1 : 33) || q !== eq || r !== er || dz !== edz) begin
                n_fail++;
                $display("FAIL random_%0d: %h/%h got q=%h r=%h dz=%b lat=%0d, want %h %h %b",
                         i, a, b, q, r, dz, lat, eq, er, edz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_edges();
        test_control();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
